// File: rtl/thermo_ramp_encoder.sv
// thermo_ramp_encoder
// Accepts a binary target level and slews an internal level register toward
// it by at most STEP per clock, presenting the level as a thermometer code.
// done pulses for one cycle when the level reaches the target.
// Optional build macro THERMO_PEAK_HOLD_EN adds a peak-hold register with
// input peak_clr and output peak (thermometer code of the highest level seen).
module thermo_ramp_encoder #(
    parameter int K    = 3,
    parameter int W    = 7,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] a,
`ifdef THERMO_PEAK_HOLD_EN
    input  logic         peak_clr,
    output logic [W-1:0] peak,
`endif
    output logic [W-1:0] q,
    output logic [K-1:0] level,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    // Step size in the one-bit-wider arithmetic domain and in the level domain.
    localparam logic [K:0]   STEP_X = (K+1)'(STEP);
    localparam logic [K-1:0] STEP_K = K'(STEP);

    state_t       state, state_nx;
    logic [K-1:0] target, target_nx;
    logic [K-1:0] level_nx;
    logic         done_nx;

    logic [K:0]   up_sum;
    logic [K:0]   dn_floor;
    logic [K-1:0] up_lvl;
    logic [K-1:0] dn_lvl;

    // Thermometer code: bit i is set exactly when i is below the level.
    function automatic logic [W-1:0] therm(input logic [K-1:0] lvl);
        logic [W-1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            t[i] = (i < int'(lvl));
        end
        return t;
    endfunction

    // Clamped one-step moves toward the target; compares are done one bit
    // wider so level+STEP and target+STEP can never wrap.
    always_comb begin
        up_sum   = {1'b0, level} + STEP_X;
        dn_floor = {1'b0, target} + STEP_X;
        up_lvl   = (up_sum >= {1'b0, target}) ? target : level + STEP_K;
        dn_lvl   = ({1'b0, level} < dn_floor) ? target : level - STEP_K;
    end

    // Next-state logic: accept a target in IDLE, otherwise step toward it.
    always_comb begin
        state_nx  = state;
        level_nx  = level;
        target_nx = target;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    target_nx = a;
                    if (a > level) begin
                        state_nx = RAMP_UP;
                    end else if (a < level) begin
                        state_nx = RAMP_DOWN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RAMP_UP: begin
                level_nx = up_lvl;
                if (up_lvl == target) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            RAMP_DOWN: begin
                level_nx = dn_lvl;
                if (dn_lvl == target) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, level, target and done registers; reset aborts any ramp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            level  <= '0;
            target <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            level  <= level_nx;
            target <= target_nx;
            done   <= done_nx;
        end
    end

    assign q        = therm(level);
    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

`ifdef THERMO_PEAK_HOLD_EN
    logic [K-1:0] peak_lvl;

    // Track the highest level; a clear reloads it with the post-edge level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_lvl <= '0;
        end else if (peak_clr) begin
            peak_lvl <= level_nx;
        end else if (level_nx > peak_lvl) begin
            peak_lvl <= level_nx;
        end
    end

    assign peak = therm(peak_lvl);
`endif

endmodule
